// File: rtl/dram_axi_pkg.sv
// Shared AXI4 read/write engine definitions: protocol constants and FSM states.
package dram_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_4K_BYTES   = 4096;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } rd_state_e;

endpackage

// File: rtl/dram_burst_calc.sv
// Beat count for the next INCR burst: limited by words left, MAX_BURST and
// the distance to the next 4 KB page boundary. Only the page offset matters.
module dram_burst_calc
    import dram_axi_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic [11:0] addr,
    input  logic [31:0] remain,
    output logic [8:0]  len
);

    logic [10:0] room;

    // Pick the smallest of the three limits; addr is word aligned so room >= 1.
    always_comb begin
        room = 11'((13'(AXI_4K_BYTES) - {1'b0, addr}) >> 2);
        len  = 9'(MAX_BURST);
        if (remain < 32'(len))
            len = remain[8:0];
        if (room < {2'b00, len})
            len = room[8:0];
    end

endmodule

// File: rtl/dram_read_engine.sv
// AXI4 read master: fetches read_num words from read_addr as 4 KB-safe INCR
// bursts, one outstanding at a time, and streams them out on buf_dout/buf_we.
module dram_read_engine
    import dram_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kick,
    output logic                  busy,
    input  logic [31:0]           read_num,
    input  logic [31:0]           read_addr,
    output logic [31:0]           buf_dout,
    output logic                  buf_we,
    output logic                  err,
    output logic [3:0]            m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    rd_state_e             state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr, next_addr, calc_addr;
    logic [31:0]           remain, next_remain, calc_remain;
    logic [8:0]            cur_len, beat_cnt, len;
    logic                  start, ar_done, beat, last_beat;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^read_addr[1:0];

    assign m_axi_arid    = 4'(AXI_ID);
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_rready  = (state == S_R);

    assign start     = (state == S_IDLE) && kick && (read_num != 32'd0);
    assign ar_done   = (state == S_AR) && m_axi_arready;
    assign beat      = (state == S_R) && m_axi_rvalid;
    assign last_beat = beat && (beat_cnt == 9'd1);

    // Where the following burst starts once the current one completes.
    assign next_addr   = addr + ADDR_WIDTH'({cur_len, 2'b00});
    assign next_remain = remain - 32'(cur_len);

    // The calculator looks at the kick parameters when idle and at the
    // post-burst position otherwise, so araddr/arlen register on S_AR entry.
    assign calc_addr   = (state == S_IDLE) ? {read_addr[ADDR_WIDTH-1:2], 2'b00} : next_addr;
    assign calc_remain = (state == S_IDLE) ? read_num : next_remain;

    dram_burst_calc #(.MAX_BURST(MAX_BURST)) u_calc (
        .addr   (calc_addr[11:0]),
        .remain (calc_remain),
        .len    (len)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state: burst ends on the beat count, never on rlast.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_AR;
            S_AR:   if (ar_done) state_nxt = S_R;
            S_R:    if (last_beat) state_nxt = (next_remain == 32'd0) ? S_IDLE : S_AR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request bookkeeping, AR channel registers, data output and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr          <= '0;
            remain        <= '0;
            cur_len       <= '0;
            beat_cnt      <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
            buf_we        <= 1'b0;
            buf_dout      <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
        end else begin
            buf_we <= beat;
            if (beat)
                buf_dout <= m_axi_rdata;

            if (start) begin
                addr          <= calc_addr;
                remain        <= read_num;
                err           <= 1'b0;
                busy          <= 1'b1;
                m_axi_arvalid <= 1'b1;
                m_axi_araddr  <= calc_addr;
                m_axi_arlen   <= 8'(len - 9'd1);
                cur_len       <= len;
            end

            if (ar_done) begin
                m_axi_arvalid <= 1'b0;
                beat_cnt      <= cur_len;
            end

            if (beat) begin
                beat_cnt <= beat_cnt - 9'd1;
                if (m_axi_rresp != AXI_RESP_OKAY || m_axi_rlast != (beat_cnt == 9'd1))
                    err <= 1'b1;
            end

            if (last_beat) begin
                addr   <= next_addr;
                remain <= next_remain;
                if (next_remain == 32'd0) begin
                    busy <= 1'b0;
                end else begin
                    m_axi_arvalid <= 1'b1;
                    m_axi_araddr  <= next_addr;
                    m_axi_arlen   <= 8'(len - 9'd1);
                    cur_len       <= len;
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_read_engine.sv
// Scoreboard bench for dram_read_engine: a randomized AXI slave with a simple
// hashed memory, expected words/ARs queued at kick time and checked by monitors.
module tb_dram_read_engine;

    localparam int MAX_BURST = 16;

    logic        clk, rst, kick, busy, buf_we, err;
    logic [31:0] read_num, read_addr, buf_dout;
    logic [3:0]  arid;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        arvalid, arready, rlast, rvalid, rready;

    typedef struct { logic [31:0] data; bit last; } word_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;

    word_t exp_q[$];
    ar_t   ar_q[$];

    int checks = 0;
    int errors = 0;

    // Slave controls set by the main sequence
    int ar_hold = 0;
    bit ar_rand = 0;
    int rv_mode = 2;
    int err_beat = -1;
    int rlast_beat = -1;
    int gbeat = 0;

    dram_read_engine #(.ADDR_WIDTH(32), .MAX_BURST(MAX_BURST), .AXI_ID(0)) dut (
        .clk(clk), .rst(rst), .kick(kick), .busy(busy),
        .read_num(read_num), .read_addr(read_addr),
        .buf_dout(buf_dout), .buf_we(buf_we), .err(err),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: every buf_we pops the next expected word.
    always @(negedge clk) begin
        word_t w;
        if (buf_we) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_word: got %0h expected none", buf_dout);
            end else begin
                w = exp_q.pop_front();
                chk("word", buf_dout, w.data);
                chk("busy_at_word", busy, !w.last);
            end
        end
    end

    // AXI slave and AR monitor, evaluated just after each falling edge.
    initial begin
        bit          act, tog, p_rst, p_av, p_arhs, p_rhs;
        logic [31:0] p_araddr, b_addr;
        logic [7:0]  p_arlen, b_len;
        int          b_idx;
        ar_t         e;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
        act = 0; tog = 0; p_rst = 1; p_av = 0; p_arhs = 0; p_rhs = 0;
        p_araddr = 0; p_arlen = 0; b_addr = 0; b_len = 0; b_idx = 0;
        forever begin
            @(negedge clk); #1;
            if (p_rst) begin
                act = 0;
            end else begin
                if (p_av && !p_arhs && arvalid) begin
                    chk("araddr_stable", araddr, p_araddr);
                    chk("arlen_stable", arlen, p_arlen);
                end
                if (p_arhs) begin
                    if (ar_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ar: got %0h/%0d expected none", p_araddr, p_arlen);
                    end else begin
                        e = ar_q.pop_front();
                        chk("ar_addr", p_araddr, e.addr);
                        chk("ar_len", p_arlen, e.len);
                    end
                    chk("ar_consts", {arid, arsize, arburst}, {4'd0, 3'b010, 2'b01});
                    act = 1; b_addr = p_araddr; b_len = p_arlen; b_idx = 0; tog = 0;
                end
                if (p_rhs) begin
                    b_idx++; gbeat++;
                    if (b_idx > int'(b_len)) act = 0;
                end
                chk("we_lag", buf_we, p_rhs);
            end
            if (rst) begin
                arready = 0; rvalid = 0; rlast = 0;
            end else if (!act) begin
                rvalid = 0; rlast = 0;
                if (ar_hold > 0) begin
                    arready = 0;
                    if (arvalid) ar_hold--;
                end else begin
                    arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end else begin
                arready = 0;
                case (rv_mode)
                    0:       rvalid = ($urandom_range(0, 3) != 0);
                    1:       begin rvalid = !tog; tog = !tog; end
                    default: rvalid = 1;
                endcase
                rdata = mem_word(b_addr + 32'(b_idx * 4));
                rresp = (gbeat == err_beat) ? 2'b10 : 2'b00;
                rlast = (b_idx == int'(b_len)) ^ (gbeat == rlast_beat);
            end
            p_rst = rst; p_av = arvalid; p_araddr = araddr; p_arlen = arlen;
            p_arhs = arvalid && arready; p_rhs = rvalid && rready;
        end
    end

    // Reference: word stream is base+4i; bursts split by words left, MAX_BURST
    // and the 4 KB page. Then pulse kick and check busy/err the next cycle.
    task automatic plan_and_kick(input logic [31:0] a, input logic [31:0] n,
                                 input int eb, input int lb);
        logic [31:0] base, cur, rem, room, l;
        word_t w;
        ar_t   r;
        base = {a[31:2], 2'b00};
        for (int i = 0; i < int'(n); i++) begin
            w.data = mem_word(base + 32'(i * 4));
            w.last = (i == int'(n) - 1);
            exp_q.push_back(w);
        end
        cur = base; rem = n;
        while (rem != 0) begin
            room = (32'd4096 - (cur % 32'd4096)) / 4;
            l = rem;
            if (l > MAX_BURST) l = MAX_BURST;
            if (l > room) l = room;
            r.addr = cur; r.len = 8'(l - 1);
            ar_q.push_back(r);
            cur = cur + l * 4;
            rem = rem - l;
        end
        err_beat = eb; rlast_beat = lb; gbeat = 0;
        @(negedge clk);
        read_addr = a; read_num = n; kick = 1;
        @(negedge clk);
        kick = 0;
        chk("busy_after_kick", busy, 1);
        chk("err_cleared_on_kick", err, 0);
    endtask

    task automatic wait_done(input bit exp_err);
        bit done;
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk); #2;
            done = !busy && exp_q.size() == 0;
        end
        chk("xfer_done", done, 1);
        chk("ar_all_issued", ar_q.size(), 0);
        chk("err_final", err, exp_err);
    endtask

    task automatic do_xfer(input logic [31:0] a, input logic [31:0] n,
                           input int eb, input int lb, input bit mid);
        plan_and_kick(a, n, eb, lb);
        if (mid) begin
            repeat (3) @(negedge clk);
            read_num = n + 5; read_addr = a + 64; kick = 1;
            @(negedge clk);
            kick = 0;
        end
        wait_done((eb >= 0 && eb < int'(n)) || (lb >= 0 && lb < int'(n)));
    endtask

    initial begin
        logic [31:0] ra, rn;
        bit          ok;
        rst = 1; kick = 0; read_num = 0; read_addr = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_we", buf_we, 0);
        chk("rst_dout", buf_dout, 0);
        chk("rst_err", err, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        rst = 0;

        // Directed cases
        do_xfer(32'h100, 1, -1, -1, 0);
        do_xfer(32'h0, 40, -1, -1, 0);
        do_xfer(32'hFF8, 4, -1, -1, 0);
        ar_hold = 10; rv_mode = 1;
        do_xfer(32'h300, 8, -1, -1, 0);
        rv_mode = 0; ar_rand = 1;
        do_xfer(32'h500, 8, 2, -1, 0);
        do_xfer(32'h600, 20, -1, 5, 0);
        do_xfer(32'h700, 8, -1, -1, 0);
        do_xfer(32'h1000, 40, -1, -1, 1);
        do_xfer(32'hFFFF_FFF9, 4, -1, -1, 0);

        // Zero-length kick is ignored
        @(negedge clk);
        read_addr = 32'h40; read_num = 0; kick = 1;
        @(negedge clk);
        kick = 0;
        repeat (4) begin
            chk("zero_kick_busy", busy, 0);
            chk("zero_kick_arvalid", arvalid, 0);
            @(negedge clk);
        end

        // Reset in the middle of a burst
        plan_and_kick(32'h2000, 40, -1, -1);
        ok = 0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk); #2;
            ok = exp_q.size() <= 30;
        end
        chk("mid_progress", ok, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_we", buf_we, 0);
        rst = 0;
        exp_q.delete();
        ar_q.delete();
        do_xfer(32'h2400, 10, -1, -1, 0);

        // Randomized transfers, some near page boundaries
        for (int t = 0; t < 12; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1)
                ra = {ra[31:12], 12'hF00} + ($urandom_range(0, 63) * 4) + ra[1:0];
            rn = $urandom_range(1, 70);
            do_xfer(ra, rn,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 69)) : -1,
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 69)) : -1, 0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
